uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART serial transmitter, the successor to the fixed 8-bit transmitter in the serial-link path. It accepts one parallel word per handshake and serialises it LSB-first with a start bit, optional parity and 1–2 stop bits. Each bit is held for a programmable number of clocks. The serial output drives the board TX pin directly and idles high.

## Interface
Parameters:
- DATA_BITS, 8, word width; legal values 5–9.
- CLK_DIV, 4, clocks per bit; must be ≥ 2.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- PARITY_ODD, 0, parity sense: 0 = even, 1 = odd. Used only when parity is compiled in.

Ports:
- iClk input 1: the block's only clock. All state changes on the rising edge.
- iRst_n input 1: reset, asynchronous and active-low.
- idata input DATA_BITS: word to send. Sampled only on an accept edge.
- iEN input 1: send request.
- oReady output 1: high only in IDLE. Reset value 1.
- odata output 1: registered serial line. Reset value 1.
- oDone output 1: one-cycle pulse at the end of a frame. Reset value 0.

## Operation
- **States:** IDLE → START → DATA → PARITY → STOP → IDLE. PARITY is skipped when parity is not compiled in.
- **Accept edge:** any rising edge where iEN && oReady is true.
  - idata is latched into the shift register.
  - Parity is computed from the latched word. Even: parity bit = XOR of all data bits. Odd: parity bit = inverted XOR of all data bits.
  - The bit counter and the divider are cleared.
  - The state moves to START.
- **Divider:** counts 0..CLK_DIV-1. A bit_tick occurs when the count equals CLK_DIV-1; the count then wraps to 0. The divider runs only outside IDLE and restarts at every accept edge, so every bit is exactly CLK_DIV clocks long.
- **START:** odata = 0 for one bit. On bit_tick, go to DATA.
- **DATA:** odata = shift register bit 0. On each bit_tick, shift right and increment the bit counter. After DATA_BITS ticks, go to PARITY or STOP.
- **PARITY:** odata = the computed parity bit for one bit. On bit_tick, go to STOP.
- **STOP:** odata = 1 for STOP_BITS bits. On the final bit_tick:
  - go to IDLE;
  - pulse oDone;
  - raise oReady.
- **iEN outside IDLE:** ignored. No queuing, and idata is not sampled.
- **idata changes mid-frame:** no effect on the frame in progress.
- **Reset asserted mid-frame:**
  - effect is immediate and asynchronous: odata = 1, oReady = 1, oDone = 0, state = IDLE;
  - the partial frame is abandoned;
  - after reset is released, no frame is sent until a new accept edge occurs.
- **Counter widths:**
  - divider: $clog2(CLK_DIV) bits;
  - bit counter: $clog2(DATA_BITS+1) bits;
  - stop counter: 1 bit.
  - No counter may overflow or wrap except at the points defined above.

## Timing
- **Accept to start bit:** 0 cycles. odata falls at the accept edge itself.
- **Frame length:** (1 + DATA_BITS + P + STOP_BITS) × CLK_DIV clocks. P = 1 with parity, 0 without.
- **End of frame:** oDone and oReady rise at the same edge that ends the last stop bit.
- **Back-to-back frames:** the minimum gap between consecutive start bits is frame length + 1 clock, because one IDLE cycle is required to accept the next word.
- **odata glitches:** none. odata comes directly from a flop.

## Configuration
- **UART_TX_PARITY_EN defined:**
  - the PARITY state and parity logic are present;
  - PARITY_ODD selects the parity sense;
  - frames contain one parity bit.
- **UART_TX_PARITY_EN undefined:**
  - no parity logic is built;
  - PARITY_ODD is ignored;
  - DATA goes straight to STOP.

## Structure
- **Shared package uart_pkg:**
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the parity-sense constants PAR_EVEN = 0 and PAR_ODD = 1.
  - uart_pkg will also serve the planned receiver.
- **Sub-module uart_baud_gen:** parameter CLK_DIV; inputs iClk, iRst_n, clear, enable; output bit_tick. The receiver will reuse it.

## Test plan
- **Even parity, 0xA5:** parity on, DATA_BITS=8, CLK_DIV=4, PARITY_ODD=0, idata=0xA5 → odata sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 clocks (44 clocks total); oDone pulses at clock 44.
- **Parity sense, 0x01:** PARITY_ODD=1 → parity bit 0; PARITY_ODD=0 → parity bit 1.
- **Busy request ignored:** pulse iEN with idata=0x3C during the DATA bits of a 0x81 frame → the frame is exactly 0x81, no second frame follows, and oReady stays 0 until the stop bit ends.
- **Back-to-back:** hold iEN high with 0x55 then 0xAA → second start bit falls 1 clock after the first oDone; both frames are bit-exact.
- **Reset mid-frame:** assert iRst_n=0 during data bit 3 → odata=1 and oReady=1 asynchronously; after release, odata stays 1 with no iEN.
- **No parity, two stop bits, 0xFF:** parity off, STOP_BITS=2, CLK_DIV=2, idata=0xFF → 0 then ten 1s, 22 clocks total, oDone at clock 22.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART transmitter and the planned receiver.
//   uart_state_e : frame sequencer states
//   PAR_EVEN     : parity-sense value selecting even parity
//   PAR_ODD      : parity-sense value selecting odd parity
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
// Bit-period divider. Counts 0..CLK_DIV-1 while enabled and flags the last
// clock of each bit period. Shared with the planned receiver.
// Parameters:
//   CLK_DIV  : clocks per bit (>= 2)
// Ports:
//   iClk     : clock
//   iRst_n   : asynchronous active-low reset
//   clear    : restart the count at 0 (frame start)
//   enable   : count while high, hold while low
//   bit_tick : high on the last clock of a bit period
module uart_baud_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    assign bit_tick = enable && (cnt_q == DW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = bit_tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity bit, STOP_BITS stop bits; each bit lasts CLK_DIV clocks.
// Build option: define UART_TX_PARITY_EN to include the parity bit
// (sense chosen by PARITY_ODD); without it frames carry no parity.
// Parameters:
//   DATA_BITS  : word width (5..9)
//   CLK_DIV    : clocks per bit (>= 2)
//   STOP_BITS  : stop bits per frame (1 or 2)
//   PARITY_ODD : 0 = even parity, 1 = odd parity
// Ports:
//   iClk   : clock
//   iRst_n : asynchronous active-low reset
//   idata  : word to send, sampled on the accept edge only
//   iEN    : send request
//   oReady : high while idle
//   odata  : registered serial line, idles high
//   oDone  : one-cycle pulse when the last stop bit ends
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int CLK_DIV    = 4,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic [DATA_BITS-1:0] idata,
    input  logic                 iEN,
    output logic                 oReady,
    output logic                 odata,
    output logic                 oDone
);

    localparam int BCW = $clog2(DATA_BITS + 1);

    // Out-of-range parameter sets leave this marker scope in the hierarchy.
    if (DATA_BITS < 5 || DATA_BITS > 9 || CLK_DIV < 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 ||
        (PARITY_ODD != PAR_EVEN && PARITY_ODD != PAR_ODD)) begin : g_illegal_params
    end

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [BCW-1:0]       bit_cnt_q;
    logic                 stop_cnt_q;
    logic                 line_q;
    logic                 ready_q;
    logic                 done_q;
    logic                 accept;
    logic                 baud_en;
    logic                 bit_tick;

`ifdef UART_TX_PARITY_EN
    logic par_q;
    logic par_d;
    assign par_d = (^idata) ^ (PARITY_ODD == PAR_ODD);
`endif

    assign accept  = iEN && ready_q;
    assign baud_en = (state_q != IDLE);

    assign oReady = ready_q;
    assign odata  = line_q;
    assign oDone  = done_q;

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .clear    (accept),
        .enable   (baud_en),
        .bit_tick (bit_tick)
    );

    // line_q is loaded with the level of the bit about to begin, so the
    // start bit appears at the accept edge and every transition is registered.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            line_q     <= 1'b1;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q    <= idata;
                        bit_cnt_q  <= '0;
                        stop_cnt_q <= 1'b0;
                        line_q     <= 1'b0;
                        ready_q    <= 1'b0;
                        state_q    <= START;
`ifdef UART_TX_PARITY_EN
                        par_q      <= par_d;
`endif
                    end
                end
                START: begin
                    if (bit_tick) begin
                        line_q  <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            line_q  <= par_q;
                            state_q <= PARITY;
`else
                            line_q  <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            line_q <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        line_q  <= 1'b1;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_tick) begin
                        if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                            line_q  <= 1'b1;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    line_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame. Two instances:
//   dut0: DATA_BITS=8, CLK_DIV=4, STOP_BITS=1, PARITY_ODD=0
//   dut1: DATA_BITS=8, CLK_DIV=2, STOP_BITS=2, PARITY_ODD=1
// A frame-level model predicts the line, ready and done outputs each cycle;
// directed frames are also captured and compared against literal frames.
module tb_uart_tx_frame;

    localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DB-1:0] data0, data1;
    logic          en0, en1;
    logic          od0, od1, rdy0, rdy1, dn0, dn1;
    logic          checking;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(
        .DATA_BITS (8), .CLK_DIV (4), .STOP_BITS (1), .PARITY_ODD (0)
    ) dut0 (
        .iClk (clk), .iRst_n (rst_n), .idata (data0), .iEN (en0),
        .oReady (rdy0), .odata (od0), .oDone (dn0)
    );

    uart_tx_frame #(
        .DATA_BITS (8), .CLK_DIV (2), .STOP_BITS (2), .PARITY_ODD (1)
    ) dut1 (
        .iClk (clk), .iRst_n (rst_n), .idata (data1), .iEN (en1),
        .oReady (rdy1), .odata (od1), .oDone (dn1)
    );

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic int sb_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int flen(input int i);
        return 1 + DB + P + sb_of(i);
    endfunction

    function automatic logic en_of(input int i);
        return (i == 0) ? en0 : en1;
    endfunction

    function automatic logic [DB-1:0] data_of(input int i);
        return (i == 0) ? data0 : data1;
    endfunction

    function automatic logic od_of(input int i);
        return (i == 0) ? od0 : od1;
    endfunction

    function automatic logic rdy_of(input int i);
        return (i == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic dn_of(input int i);
        return (i == 0) ? dn0 : dn1;
    endfunction

    // Frame as a bit list in send order; positions past the frame read 1.
    function automatic logic [12:0] frame_bits(input int i, input logic [DB-1:0] d);
        logic [12:0] f;
        logic        p;
        f    = '1;
        p    = 1'b0;
        f[0] = 1'b0;
        for (int k = 0; k < DB; k++) begin
            f[1+k] = d[k];
            p      = p ^ d[k];
        end
        if (P == 1) f[1+DB] = (i == 1) ? ~p : p;
        return f;
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_cnt counts clocks since the accept edge; the bit on the line
    // is frame position m_cnt / CLK_DIV until the frame length has elapsed.
    logic        m_busy [2];
    logic        m_done [2];
    int          m_cnt  [2];
    logic [12:0] m_fb   [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_cnt[i]  <= 0;
                m_fb[i]   <= '1;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_done[i] <= 1'b0;
                if (!m_busy[i]) begin
                    if (en_of(i)) begin
                        m_busy[i] <= 1'b1;
                        m_cnt[i]  <= 0;
                        m_fb[i]   <= frame_bits(i, data_of(i));
                    end
                end else if (m_cnt[i] + 1 == flen(i) * div_of(i)) begin
                    m_busy[i] <= 1'b0;
                    m_done[i] <= 1'b1;
                end else begin
                    m_cnt[i] <= m_cnt[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking && rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("dut%0d odata", i), od_of(i),
                    m_busy[i] ? m_fb[i][m_cnt[i] / div_of(i)] : 1'b1);
                chk($sformatf("dut%0d oReady", i), rdy_of(i), ~m_busy[i]);
                chk($sformatf("dut%0d oDone", i), dn_of(i), m_done[i]);
            end
        end
    end

    task automatic start_frame(input int i, input logic [DB-1:0] d);
        @(posedge clk);
        #1;
        if (i == 0) begin en0 = 1'b1; data0 = d; end
        else        begin en1 = 1'b1; data1 = d; end
        @(posedge clk);
        #1;
        if (i == 0) en0 = 1'b0;
        else        en1 = 1'b0;
    endtask

    // Entered just after an accept edge; iteration n samples after edge n.
    task automatic capture(input int i, input int pulse_at,
                           output logic [12:0] bits, output int done_at);
        bits    = '1;
        done_at = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if ((n % div_of(i)) == 0 && (n / div_of(i)) < 13)
                bits[n / div_of(i)] = od_of(i);
            if (pulse_at >= 0 && n == pulse_at) begin
                en0   = 1'b1;
                data0 = 8'h3C;
            end
            if (pulse_at >= 0 && n == pulse_at + 1) en0 = 1'b0;
            if (dn_of(i)) begin
                done_at = n;
                break;
            end
        end
    endtask

    logic [12:0] bits;
    int          done_at;

    initial begin
        en0 = 1'b0; en1 = 1'b0; data0 = '0; data1 = '0;
        checking = 1'b0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("reset dut0 odata", od0, 1'b1);
        chk("reset dut0 oReady", rdy0, 1'b1);
        chk("reset dut0 oDone", dn0, 1'b0);
        chk("reset dut1 odata", od1, 1'b1);
        chk("reset dut1 oReady", rdy1, 1'b1);
        chk("reset dut1 oDone", dn1, 1'b0);
        checking = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // 0xA5 on dut0
        start_frame(0, 8'hA5);
        capture(0, -1, bits, done_at);
`ifdef UART_TX_PARITY_EN
        chk_int("A5 frame", int'(bits), int'({3'b111, 1'b0, 8'hA5, 1'b0}));
        chk_int("A5 done clock", done_at, 44);
`else
        chk_int("A5 frame", int'(bits), int'({4'b1111, 8'hA5, 1'b0}));
        chk_int("A5 done clock", done_at, 40);
`endif

        // 0x01 on both senses
        start_frame(0, 8'h01);
        capture(0, -1, bits, done_at);
`ifdef UART_TX_PARITY_EN
        chk_int("01 even frame", int'(bits), int'({3'b111, 1'b1, 8'h01, 1'b0}));
        chk_int("01 even done clock", done_at, 44);
`else
        chk_int("01 dut0 frame", int'(bits), int'({4'b1111, 8'h01, 1'b0}));
        chk_int("01 dut0 done clock", done_at, 40);
`endif
        start_frame(1, 8'h01);
        capture(1, -1, bits, done_at);
`ifdef UART_TX_PARITY_EN
        chk_int("01 odd frame", int'(bits), int'({3'b111, 1'b0, 8'h01, 1'b0}));
        chk_int("01 odd done clock", done_at, 24);
`else
        chk_int("01 dut1 frame", int'(bits), int'({4'b1111, 8'h01, 1'b0}));
        chk_int("01 dut1 done clock", done_at, 22);
`endif

        // busy request ignored: 0x3C pulsed during the data bits of 0x81
        start_frame(0, 8'h81);
        capture(0, 10, bits, done_at);
`ifdef UART_TX_PARITY_EN
        chk_int("81 frame", int'(bits), int'({3'b111, 1'b0, 8'h81, 1'b0}));
        chk_int("81 done clock", done_at, 44);
`else
        chk_int("81 frame", int'(bits), int'({4'b1111, 8'h81, 1'b0}));
        chk_int("81 done clock", done_at, 40);
`endif
        repeat (30) @(negedge clk);
        chk("idle after busy req odata", od0, 1'b1);
        chk("idle after busy req oReady", rdy0, 1'b1);

        // back-to-back 0x55 then 0xAA with iEN held high
        @(posedge clk);
        #1 en0 = 1'b1; data0 = 8'h55;
        @(posedge clk);
        #1 data0 = 8'hAA;
        capture(0, -1, bits, done_at);
`ifdef UART_TX_PARITY_EN
        chk_int("55 frame", int'(bits), int'({3'b111, 1'b0, 8'h55, 1'b0}));
`else
        chk_int("55 frame", int'(bits), int'({4'b1111, 8'h55, 1'b0}));
`endif
        @(posedge clk);
        #1 en0 = 1'b0;
        capture(0, -1, bits, done_at);
`ifdef UART_TX_PARITY_EN
        chk_int("AA frame", int'(bits), int'({3'b111, 1'b0, 8'hAA, 1'b0}));
        chk_int("AA done clock", done_at, 44);
`else
        chk_int("AA frame", int'(bits), int'({4'b1111, 8'hAA, 1'b0}));
        chk_int("AA done clock", done_at, 40);
`endif

        // reset during data bit 3 of 0xC3 (bit 3 is 0)
        start_frame(0, 8'hC3);
        repeat (17) @(negedge clk);
        chk("C3 data bit 3 before reset", od0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-frame reset odata", od0, 1'b1);
        chk("mid-frame reset oReady", rdy0, 1'b1);
        chk("mid-frame reset oDone", dn0, 1'b0);
        #5 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("after reset line idle", od0, 1'b1);
        chk("after reset oReady", rdy0, 1'b1);

        // 0xFF on dut1, two stop bits, CLK_DIV=2
        start_frame(1, 8'hFF);
        capture(1, -1, bits, done_at);
        chk_int("FF frame", int'(bits), int'({4'b1111, 8'hFF, 1'b0}));
`ifdef UART_TX_PARITY_EN
        chk_int("FF done clock", done_at, 24);
`else
        chk_int("FF done clock", done_at, 22);
`endif
        repeat (10) @(negedge clk);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
